// File: rtl/mdu_pkg.sv
// Shared multiply/divide definitions: op encodings, default latencies and result payload.
package mdu_pkg;

  localparam int unsigned MDU_OP_W        = 4;
  localparam int unsigned MDU_DATA_W      = 32;
  localparam int unsigned MULT_CYCLES_DEF = 5;
  localparam int unsigned DIV_CYCLES_DEF  = 10;

  typedef enum logic [MDU_OP_W-1:0] {
    OP_NONE  = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MFHI  = 4'd5,
    OP_MFLO  = 4'd6,
    OP_MTHI  = 4'd7,
    OP_MTLO  = 4'd8
  } mdu_op_e;

  typedef struct packed {
    logic [MDU_DATA_W-1:0] hi;
    logic [MDU_DATA_W-1:0] lo;
  } mdu_res_t;

  function automatic logic is_mul_op(input logic [MDU_OP_W-1:0] op);
    return (op == OP_MULT) || (op == OP_MULTU);
  endfunction

  function automatic logic is_div_op(input logic [MDU_OP_W-1:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/mdu_calc.sv
// Combinational datapath producing {hi,lo} for the latched operation.
// Divider present only when MDU_DIV_EN is defined.
module mdu_calc
  import mdu_pkg::*;
(
  input  logic [MDU_DATA_W-1:0] a_i,
  input  logic [MDU_DATA_W-1:0] b_i,
  input  logic [MDU_OP_W-1:0]   op_i,
  output mdu_res_t              res_c_o,
  output logic                  div_by_zero_c_o
);

  logic signed [2*MDU_DATA_W-1:0] a_sx, b_sx, smul;
  logic        [2*MDU_DATA_W-1:0] umul;

  assign a_sx = {{MDU_DATA_W{a_i[MDU_DATA_W-1]}}, a_i};
  assign b_sx = {{MDU_DATA_W{b_i[MDU_DATA_W-1]}}, b_i};
  assign smul = a_sx * b_sx;
  assign umul = {{MDU_DATA_W{1'b0}}, a_i} * {{MDU_DATA_W{1'b0}}, b_i};

`ifdef MDU_DIV_EN
  // One unsigned divider serves both forms; signed division runs on magnitudes.
  logic                  sgn, a_neg, b_neg, b_zero;
  logic [MDU_DATA_W-1:0] ua, ub, uq, ur, quo, rem;

  always_comb begin
    sgn    = (op_i == OP_DIV);
    a_neg  = sgn && a_i[MDU_DATA_W-1];
    b_neg  = sgn && b_i[MDU_DATA_W-1];
    b_zero = (b_i == '0);
    ua     = a_neg ? (~a_i + MDU_DATA_W'(1)) : a_i;
    ub     = b_zero ? MDU_DATA_W'(1) : (b_neg ? (~b_i + MDU_DATA_W'(1)) : b_i);
    uq     = ua / ub;
    ur     = ua % ub;
    quo    = (a_neg ^ b_neg) ? (~uq + MDU_DATA_W'(1)) : uq;
    rem    = a_neg ? (~ur + MDU_DATA_W'(1)) : ur;
  end

  assign div_by_zero_c_o = is_div_op(op_i) && b_zero;
`else
  assign div_by_zero_c_o = 1'b0;
`endif

  always_comb begin
    res_c_o = '0;
    case (op_i)
      OP_MULT:  res_c_o = mdu_res_t'(smul);
      OP_MULTU: res_c_o = mdu_res_t'(umul);
`ifdef MDU_DIV_EN
      OP_DIV, OP_DIVU: begin
        res_c_o.hi = rem;
        res_c_o.lo = quo;
      end
`endif
      default:  res_c_o = '0;
    endcase
  end

endmodule

// File: rtl/mdu_unit.sv
// E-stage multiply/divide unit: fixed-latency MULT/DIV, HI/LO ownership, MF*/MT* service.
// Divide support is compiled in only when MDU_DIV_EN is defined.
module mdu_unit
  import mdu_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [MDU_DATA_W-1:0] A,
  input  logic [MDU_DATA_W-1:0] B,
  input  logic [MDU_OP_W-1:0]   mdu_op,
  input  logic                  start,
  output logic                  busy,
  output logic                  mdu_block,
  output logic [MDU_DATA_W-1:0] hi_lo_out
);

  localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

  logic [MDU_DATA_W-1:0] a_q, a_d, b_q, b_d, hi_q, hi_d, lo_q, lo_d;
  logic [MDU_OP_W-1:0]   op_q, op_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  busy_q, busy_d;
  logic                  op_mul, op_div, launch;
  mdu_res_t              res;
  logic                  div_by_zero;

  mdu_calc u_calc (
    .a_i             (a_q),
    .b_i             (b_q),
    .op_i            (op_q),
    .res_c_o         (res),
    .div_by_zero_c_o (div_by_zero)
  );

  always_comb begin
    op_mul = is_mul_op(mdu_op);
`ifdef MDU_DIV_EN
    op_div = is_div_op(mdu_op);
`else
    op_div = 1'b0;
`endif
  end

  // Counter, operand latches and HI/LO update; MT* and new starts are blocked while busy.
  always_comb begin
    a_d    = a_q;
    b_d    = b_q;
    op_d   = op_q;
    cnt_d  = cnt_q;
    hi_d   = hi_q;
    lo_d   = lo_q;
    launch = start && !busy_q && (op_mul || op_div);
    if (busy_q) begin
      cnt_d = cnt_q - CNT_W'(1);
      if ((cnt_q == CNT_W'(1)) && !div_by_zero) begin
        hi_d = res.hi;
        lo_d = res.lo;
      end
    end else if (launch) begin
      a_d   = A;
      b_d   = B;
      op_d  = mdu_op;
      cnt_d = op_mul ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
    end else if (mdu_op == OP_MTHI) begin
      hi_d = A;
    end else if (mdu_op == OP_MTLO) begin
      lo_d = A;
    end
    busy_d = (cnt_d != '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_q    <= '0;
      b_q    <= '0;
      op_q   <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
    end else begin
      a_q    <= a_d;
      b_q    <= b_d;
      op_q   <= op_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      hi_q   <= hi_d;
      lo_q   <= lo_d;
    end
  end

  assign busy = busy_q;

`ifdef MDU_DIV_EN
  assign mdu_block = start | busy_q;
`else
  assign mdu_block = (start & op_mul) | busy_q;
`endif

  always_comb begin
    case (mdu_op)
      OP_MFHI: hi_lo_out = hi_q;
      OP_MFLO: hi_lo_out = lo_q;
      default: hi_lo_out = '0;
    endcase
  end

endmodule

// File: tb/tb_mdu_unit.sv
// Scoreboard bench for mdu_unit: directed cases then random traffic against a 64-bit arithmetic model.
module tb_mdu_unit;
  import mdu_pkg::*;

`ifdef MDU_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] A, B;
  logic [3:0]  mdu_op;
  logic        start;
  logic        busy, mdu_block;
  logic [31:0] hi_lo_out;

  always #5 clk = ~clk;

  mdu_unit dut (
    .clk       (clk),
    .reset     (reset),
    .A         (A),
    .B         (B),
    .mdu_op    (mdu_op),
    .start     (start),
    .busy      (busy),
    .mdu_block (mdu_block),
    .hi_lo_out (hi_lo_out)
  );

  typedef struct {
    bit          busy;
    bit          blk;
    logic [31:0] out;
    string       tag;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  bit   armed    = 1'b0;

  // Architectural model: HI/LO, cycles left, result that lands when the count expires.
  logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
  int          m_rem = 0;
  bit          p_dbz = 1'b0;

  function automatic bit launches(input logic [3:0] op);
    return (op == 4'd1) || (op == 4'd2) || (DIV_EN && ((op == 4'd3) || (op == 4'd4)));
  endfunction

  task automatic model_step(input bit r, input logic [3:0] op, input bit st,
                            input logic [31:0] a, input logic [31:0] b);
    longint          sp, sq, sr;
    longint unsigned up;
    if (r) begin
      m_hi = '0; m_lo = '0; m_rem = 0;
    end else if (m_rem > 0) begin
      m_rem--;
      if (m_rem == 0 && !p_dbz) begin
        m_hi = p_hi; m_lo = p_lo;
      end
    end else if (st && launches(op)) begin
      p_dbz = 1'b0;
      case (op)
        4'd1: begin
          sp = longint'($signed(a)) * longint'($signed(b));
          p_hi = sp[63:32]; p_lo = sp[31:0]; m_rem = 5;
        end
        4'd2: begin
          up = 64'(a) * 64'(b);
          p_hi = up[63:32]; p_lo = up[31:0]; m_rem = 5;
        end
        4'd3: begin
          m_rem = 10;
          if (b == 0) p_dbz = 1'b1;
          else begin
            sq = longint'($signed(a)) / longint'($signed(b));
            sr = longint'($signed(a)) % longint'($signed(b));
            p_lo = sq[31:0]; p_hi = sr[31:0];
          end
        end
        default: begin
          m_rem = 10;
          if (b == 0) p_dbz = 1'b1;
          else begin
            up = 64'(a) / 64'(b); p_lo = up[31:0];
            up = 64'(a) % 64'(b); p_hi = up[31:0];
          end
        end
      endcase
    end else if (op == 4'd7) begin
      m_hi = a;
    end else if (op == 4'd8) begin
      m_lo = a;
    end
  endtask

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=%h required=%h", name, act, req);
    end
  endtask

  // Monitor: every cycle the DUT presents busy/mdu_block/hi_lo_out, check them against the queue head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        cmp({e.tag, " busy"},      32'(busy),      32'(e.busy));
        cmp({e.tag, " mdu_block"}, 32'(mdu_block), 32'(e.blk));
        cmp({e.tag, " hi_lo_out"}, hi_lo_out,      e.out);
      end
    end
  end

  task automatic drive_x(input bit r, input logic [3:0] op, input bit st,
                         input logic [31:0] a, input logic [31:0] b, input string tag,
                         input bit ovr, input logic [31:0] ovr_val);
    exp_t e;
    reset = r; mdu_op = op; start = st; A = a; B = b;
    e.busy = (m_rem != 0);
    e.blk  = (st && launches(op)) || (m_rem != 0);
    e.out  = ovr ? ovr_val : ((op == 4'd5) ? m_hi : ((op == 4'd6) ? m_lo : 32'h0));
    e.tag  = tag;
    if (armed) exp_q.push_back(e);
    @(posedge clk);
    model_step(r, op, st, a, b);
    #1;
  endtask

  task automatic drive(input bit r, input logic [3:0] op, input bit st,
                       input logic [31:0] a, input logic [31:0] b, input string tag);
    drive_x(r, op, st, a, b, tag, 1'b0, 32'h0);
  endtask

  task automatic expect_reg(input logic [3:0] op, input logic [31:0] val, input string tag);
    drive_x(1'b0, op, 1'b0, $urandom, $urandom, tag, 1'b1, val);
  endtask

  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input string tag);
    drive(1'b0, op, 1'b1, a, b, tag);
    for (int i = 0; i < 20 && m_rem > 0; i++) drive(1'b0, 4'd0, 1'b0, $urandom, $urandom, tag);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'h8000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'($urandom_range(0, 20));
      3:       return -32'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [3:0]  op;
    logic [31:0] ra, rb;
    bit          st, rr;

    drive(1'b1, 4'd0, 1'b0, 32'h0, 32'h0, "rst");
    armed = 1'b1;
    drive(1'b1, 4'd0, 1'b0, 32'h0, 32'h0, "rst");
    expect_reg(4'd5, 32'h0, "reset hi");
    expect_reg(4'd6, 32'h0, "reset lo");

    run_op(4'd1, 32'hFFFF_FFFF, 32'h2, "mult");
    expect_reg(4'd5, 32'hFFFF_FFFF, "mult hi");
    expect_reg(4'd6, 32'hFFFF_FFFE, "mult lo");
    run_op(4'd2, 32'hFFFF_FFFF, 32'h2, "multu");
    expect_reg(4'd5, 32'h0000_0001, "multu hi");
    expect_reg(4'd6, 32'hFFFF_FFFE, "multu lo");

    run_op(4'd3, 32'hFFFF_FFF9, 32'h2, "div");
    expect_reg(4'd5, DIV_EN ? 32'hFFFF_FFFF : 32'h0000_0001, "div hi");
    expect_reg(4'd6, DIV_EN ? 32'hFFFF_FFFD : 32'hFFFF_FFFE, "div lo");
    run_op(4'd4, 32'h7, 32'h2, "divu");
    expect_reg(4'd5, DIV_EN ? 32'h1 : 32'h0000_0001, "divu hi");
    expect_reg(4'd6, DIV_EN ? 32'h3 : 32'hFFFF_FFFE, "divu lo");

    drive(1'b0, 4'd7, 1'b0, 32'h11, 32'h0, "mthi");
    drive(1'b0, 4'd8, 1'b0, 32'h22, 32'h0, "mtlo");
    run_op(4'd3, 32'h1234, 32'h0, "div0");
    expect_reg(4'd5, 32'h11, "div0 hi");
    expect_reg(4'd6, 32'h22, "div0 lo");
    run_op(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, "divovf");
    expect_reg(4'd5, DIV_EN ? 32'h0 : 32'h11, "divovf hi");
    expect_reg(4'd6, DIV_EN ? 32'h8000_0000 : 32'h22, "divovf lo");

    drive(1'b0, 4'd1, 1'b1, 32'h3, 32'h4, "inflight");
    drive(1'b0, 4'd0, 1'b0, 32'h0, 32'h0, "inflight");
    drive(1'b0, 4'd3, 1'b1, 32'h99, 32'h5, "inflight 2nd start");
    drive(1'b0, 4'd8, 1'b0, 32'h55, 32'h0, "inflight mtlo");
    for (int i = 0; i < 20 && m_rem > 0; i++) drive(1'b0, 4'd0, 1'b0, 32'h0, 32'h0, "inflight");
    expect_reg(4'd5, 32'h0, "inflight hi");
    expect_reg(4'd6, 32'hC, "inflight lo");

    drive(1'b0, 4'd3, 1'b1, 32'd100, 32'd7, "rstdiv");
    drive(1'b0, 4'd0, 1'b0, 32'h0, 32'h0, "rstdiv");
    drive(1'b0, 4'd0, 1'b0, 32'h0, 32'h0, "rstdiv");
    drive(1'b1, 4'd0, 1'b0, 32'h0, 32'h0, "rstdiv reset");
    for (int i = 0; i < 12; i++) drive(1'b0, 4'd6, 1'b0, 32'h0, 32'h0, "rstdiv after");
    expect_reg(4'd5, 32'h0, "rstdiv hi");
    expect_reg(4'd6, 32'h0, "rstdiv lo");

    run_op(4'd1, 32'h5, 32'h6, "block");
    drive(1'b0, 4'd7, 1'b0, 32'hABCD, 32'h0, "mthi abcd");
    expect_reg(4'd5, 32'hABCD, "mfhi abcd");

    for (int n = 0; n < 400; n++) begin
      rr = ($urandom_range(0, 99) == 0);
      op = 4'($urandom_range(0, 11));
      if (op > 4'd8) op = 4'($urandom_range(9, 15));
      st = (op >= 4'd1) && (op <= 4'd4) && ($urandom_range(0, 3) != 0);
      ra = pick();
      rb = ($urandom_range(0, 7) == 0) ? 32'h0 : pick();
      drive(rr, op, st, ra, rb, "rand");
    end
    drive(1'b0, 4'd0, 1'b0, 32'h0, 32'h0, "drain");

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain: pending=%0d required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
